// File: rtl/e_scale_param_loader_pkg.sv
// Shared definitions for the E_scale parameter path: loader FSM states,
// header field layout and tail width. The consumer imports this for rank width.
package e_scale_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int TAIL_W   = 16;
  localparam int RANK_LSB = 0;
  localparam int RANK_W   = 6;
  localparam int CSUM_LSB = 16;

endpackage

// File: rtl/e_scale_param_loader_if.sv
// Input beat stream (header + tail beats) into the E_scale parameter loader.
interface e_scale_param_loader_if #(
  parameter int LANES_PER_BEAT = 4
);
  import e_scale_pkg::*;

  logic                             s_valid;
  logic                             s_ready;
  logic [TAIL_W*LANES_PER_BEAT-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/e_scale_param_loader_bank.sv
// DSP_NUM x 16-bit register bank. Written one beat (LANES_PER_BEAT tails) at a
// time by beat index, or overwritten as a whole from another bank.
module e_scale_bank
  import e_scale_pkg::*;
#(
  parameter int DSP_NUM        = 192,
  parameter int LANES_PER_BEAT = 4,
  localparam int BEATS         = DSP_NUM / LANES_PER_BEAT,
  localparam int IDX_W         = $clog2(BEATS),
  localparam int BEAT_W        = TAIL_W * LANES_PER_BEAT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [BEAT_W-1:0]       wr_data,
  input  logic                    copy_en,
  input  logic [TAIL_W*DSP_NUM-1:0] copy_data,
  output logic [TAIL_W*DSP_NUM-1:0] bank_data
);

  // Whole-bank copy has priority over a beat write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bank_data <= '0;
    end else if (copy_en) begin
      bank_data <= copy_data;
    end else if (wr_en) begin
      for (int k = 0; k < BEATS; k++) begin
        if (wr_idx == IDX_W'(k)) bank_data[k*BEAT_W +: BEAT_W] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/e_scale_param_loader.sv
// E_scale parameter loader: assembles a shadow set of DSP_NUM tails plus a
// shift rank from the beat stream and swaps it into the active bank when the
// consumer is idle or finishes its tile. Active outputs only change on swap.
// Optional feature: define E_SCALE_CSUM_EN to check the header XOR checksum.
//
// state | meaning
// HDR   | waiting for header beat (rank, checksum)
// LOAD  | accepting BEATS data beats into the shadow bank
// FULL  | shadow complete, waiting to swap into active
module e_scale_param_loader
  import e_scale_pkg::*;
#(
  parameter int DSP_NUM        = 192,
  parameter int LANES_PER_BEAT = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  e_scale_param_loader_if.slave     s_if,
  input  logic                      tile_done,
  output logic [TAIL_W*DSP_NUM-1:0] E_scale_tail,
  output logic [RANK_W-1:0]         scale_rank,
  output logic                      param_valid,
  output logic                      load_err
);

  localparam int BEATS = DSP_NUM / LANES_PER_BEAT;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic                      accept, hdr_take, beat_take, swap, csum_ok;
  logic [RANK_W-1:0]         shadow_rank;
  logic [TAIL_W*DSP_NUM-1:0] shadow_data;

  assign s_if.s_ready = (state_q != FULL);
  assign accept       = s_if.s_valid && s_if.s_ready;

  // State and beat counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, beat counter and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_take  = 1'b0;
    beat_take = 1'b0;
    swap      = 1'b0;
    case (state_q)
      HDR: begin
        if (accept) begin
          hdr_take = 1'b1;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          beat_take = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = csum_ok ? FULL : HDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (!param_valid || tile_done) begin
          swap    = 1'b1;
          cnt_d   = '0;
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  // Shadow rank capture, active rank and validity; tile_done retires the active set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_rank <= '0;
      scale_rank  <= '0;
      param_valid <= 1'b0;
    end else begin
      if (hdr_take) shadow_rank <= s_if.s_data[RANK_LSB +: RANK_W];
      if (swap) begin
        scale_rank  <= shadow_rank;
        param_valid <= 1'b1;
      end else if (tile_done) begin
        param_valid <= 1'b0;
      end
    end
  end

`ifdef E_SCALE_CSUM_EN
  logic [TAIL_W-1:0] beat_fold, csum_acc, csum_hdr;
  logic              err_q;

  // XOR of the tails in the current beat.
  always_comb begin
    beat_fold = '0;
    for (int l = 0; l < LANES_PER_BEAT; l++) beat_fold ^= s_if.s_data[l*TAIL_W +: TAIL_W];
  end

  assign csum_ok  = ((csum_acc ^ beat_fold) == csum_hdr);
  assign load_err = err_q;

  // Checksum accumulation over the set and sticky error on a bad final compare.
  always_ff @(posedge CLK) begin
    if (RST) begin
      csum_acc <= '0;
      csum_hdr <= '0;
      err_q    <= 1'b0;
    end else begin
      if (hdr_take) begin
        csum_hdr <= s_if.s_data[CSUM_LSB +: TAIL_W];
        csum_acc <= '0;
      end else if (beat_take) begin
        csum_acc <= csum_acc ^ beat_fold;
      end
      if (beat_take && (cnt_q == LAST_IDX) && !csum_ok) err_q <= 1'b1;
    end
  end
`else
  assign csum_ok  = 1'b1;
  assign load_err = 1'b0;
`endif

  e_scale_bank #(.DSP_NUM(DSP_NUM), .LANES_PER_BEAT(LANES_PER_BEAT)) u_shadow (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (beat_take),
    .wr_idx    (cnt_q),
    .wr_data   (s_if.s_data),
    .copy_en   (1'b0),
    .copy_data ('0),
    .bank_data (shadow_data)
  );

  e_scale_bank #(.DSP_NUM(DSP_NUM), .LANES_PER_BEAT(LANES_PER_BEAT)) u_active (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .copy_en   (swap),
    .copy_data (shadow_data),
    .bank_data (E_scale_tail)
  );

endmodule

// File: tb/tb_e_scale_param_loader.sv
// Bench for e_scale_param_loader: directed sets with randomized content and
// pacing, checked against a transaction-level model of the active/shadow sets.
module tb_e_scale_param_loader;

  localparam int DSP_NUM = 192;
  localparam int LPB     = 4;
  localparam int BEATS   = DSP_NUM / LPB;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  tile_done;
  logic [16*DSP_NUM-1:0] E_scale_tail;
  logic [5:0]            scale_rank;
  logic                  param_valid;
  logic                  load_err;

  e_scale_param_loader_if #(.LANES_PER_BEAT(LPB)) s_if ();

  e_scale_param_loader #(.DSP_NUM(DSP_NUM), .LANES_PER_BEAT(LPB)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .s_if         (s_if.slave),
    .tile_done    (tile_done),
    .E_scale_tail (E_scale_tail),
    .scale_rank   (scale_rank),
    .param_valid  (param_valid),
    .load_err     (load_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // model: active set, pending complete set, sticky error
  logic [15:0] m_act [DSP_NUM];
  logic [15:0] m_sh  [DSP_NUM];
  logic [5:0]  m_rank, m_sh_rank;
  bit          m_valid, m_pend, m_err;

  // set currently being sent
  logic [15:0] cur_tail [DSP_NUM];
  logic [5:0]  cur_rank;
  logic [15:0] cur_csum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [15:0] xor_tails();
    logic [15:0] x = '0;
    for (int i = 0; i < DSP_NUM; i++) x ^= cur_tail[i];
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DSP_NUM; i++) begin
      m_act[i] = '0;
      m_sh[i]  = '0;
    end
    m_rank = '0; m_sh_rank = '0;
    m_valid = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1; s_if.s_valid = 1'b0; s_if.s_data = '0; tile_done = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, advance one edge, update the model.
  task automatic step(input bit v, input logic [63:0] d, input bit td, input int pos, output bit acc);
    bit swap;
    s_if.s_valid = v; s_if.s_data = d; tile_done = td;
    acc = v && !m_pend;
    chk("s_ready", s_if.s_ready, !m_pend);
    @(posedge CLK);
    #1;
    swap = m_pend && (!m_valid || td);
    if (swap) begin
      for (int i = 0; i < DSP_NUM; i++) m_act[i] = m_sh[i];
      m_rank = m_sh_rank; m_valid = 1; m_pend = 0;
    end else if (td) begin
      m_valid = 0;
    end
    if (acc && pos == BEATS) begin
`ifdef E_SCALE_CSUM_EN
      if (xor_tails() != cur_csum) m_err = 1;
      else begin
`else
      begin
`endif
        for (int i = 0; i < DSP_NUM; i++) m_sh[i] = cur_tail[i];
        m_sh_rank = cur_rank; m_pend = 1;
      end
    end
    s_if.s_valid = 1'b0; tile_done = 1'b0;
  endtask

  task automatic idle(input int n, input bit td_rand);
    bit acc;
    for (int c = 0; c < n; c++) step(1'b0, '0, td_rand && ($urandom_range(0, 3) == 0), 0, acc);
  endtask

  task automatic fill(input int mode, input logic [5:0] rank, input bit bad);
    for (int i = 0; i < DSP_NUM; i++)
      cur_tail[i] = (mode == 0) ? 16'(i) : (mode == 1) ? 16'(100 + i) : 16'($urandom);
    cur_rank = rank;
    cur_csum = xor_tails() ^ (bad ? 16'h0001 : 16'h0000);
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  // abort: stop after this many data beats (-1 = send whole set).
  task automatic send_set(input int gap_mode, input bit td_last, input int abort);
    int pos = 0, cyc = 0;
    bit v, acc, td;
    logic [63:0] d;
    while (pos <= BEATS) begin
      if (abort >= 0 && pos == abort + 1) return;
      if (cyc > 2000) begin
        chk("send_timeout", 32'(pos), 32'(BEATS + 1));
        return;
      end
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (pos == 0) begin
        d = {$urandom, $urandom};
        d[5:0]   = cur_rank;
        d[31:16] = cur_csum;
      end else begin
        for (int l = 0; l < LPB; l++) d[16*l +: 16] = cur_tail[(pos-1)*LPB + l];
      end
      td = td_last && (pos == BEATS) && v;
      step(v, d, td, pos, acc);
      if (acc) pos++;
      cyc++;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < DSP_NUM; i++) chk({tag, "_lane"}, E_scale_tail[16*i +: 16], m_act[i]);
    chk({tag, "_rank"}, scale_rank, m_rank);
    chk({tag, "_valid"}, param_valid, m_valid);
    chk({tag, "_err"}, load_err, m_err);
  endtask

  initial begin
    do_reset();
    check_all("reset");
    chk("reset_ready", s_if.s_ready, 1'b1);

    // first set: rank -2, tail i; swaps one cycle after last beat
    fill(0, 6'h3E, 0);
    send_set(0, 0, -1);
    chk("t1_pre_swap_valid", param_valid, 1'b0);
    chk("t1_full_ready", s_if.s_ready, 1'b0);
    idle(1, 0);
    check_all("t1");
    chk("t1_lane5", E_scale_tail[16*5 +: 16], 16'd5);
    chk("t1_rank", scale_rank, 6'h3E);
    chk("t1_valid", param_valid, 1'b1);

    // second set held in FULL until tile_done
    fill(1, 6'd3, 0);
    send_set(0, 0, -1);
    idle(3, 0);
    check_all("t2_hold");
    chk("t2_hold_lane5", E_scale_tail[16*5 +: 16], 16'd5);
    begin
      bit acc;
      step(1'b0, '0, 1'b1, 0, acc);
    end
    check_all("t2_swap");
    chk("t2_lane5", E_scale_tail[16*5 +: 16], 16'd105);
    chk("t2_rank", scale_rank, 6'd3);

    // gapped valid reproduces set 1
    fill(0, 6'h3E, 0);
    send_set(1, 0, -1);
    begin
      bit acc;
      step(1'b0, '0, 1'b1, 0, acc);
    end
    check_all("t3");
    chk("t3_lane47", E_scale_tail[16*47 +: 16], 16'd47);

    // random sets, random pacing and tile_done pulses
    for (int r = 0; r < 4; r++) begin
      fill(2, 6'($urandom), 0);
      send_set(2, 0, -1);
      idle($urandom_range(1, 6), 1);
      check_all("rand");
    end

    // reset mid-load, then a fresh set
    fill(2, 6'h15, 0);
    send_set(0, 0, 20);
    do_reset();
    check_all("t4_reset");
    chk("t4_zero_valid", param_valid, 1'b0);
    fill(2, 6'h2A, 0);
    send_set(2, 0, -1);
    idle(1, 0);
    check_all("t4_fresh");

    // tile_done with last data beat: one cycle of param_valid=0
    fill(2, 6'h07, 0);
    send_set(0, 1, -1);
    chk("t5_retired", param_valid, 1'b0);
    idle(1, 0);
    chk("t5_swapped", param_valid, 1'b1);
    check_all("t5");

`ifdef E_SCALE_CSUM_EN
    // bad checksum discarded, later good set still swaps, error sticks
    fill(2, 6'h11, 1);
    send_set(0, 0, -1);
    idle(2, 0);
    chk("t6_err", load_err, 1'b1);
    check_all("t6_bad");
    fill(2, 6'h12, 0);
    send_set(0, 0, -1);
    begin
      bit acc;
      step(1'b0, '0, 1'b1, 0, acc);
    end
    check_all("t6_good");
    chk("t6_err_sticky", load_err, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
